// File: rtl/dynamic_output_rr_scheduler.sv
// Wormhole output scheduler: round-robin arbitration among five requesters,
// with the route held until the packet's tail and downstream credit flow control.
module dynamic_output_rr_scheduler #(
    parameter int CREDITS = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       route_req_in,
    input  logic [4:0]       valid_in,
    input  logic [4:0]       tail_in,
    input  logic             yummy_in,
    output logic [2:0]       current_route,
    output logic             valid_out,
    output logic [4:0]       thanks_out,
    output logic             locked,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             ec_wants_to_send_but_cannot,
    output logic             credit_overflow_err
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t     state;
    logic [2:0] rr_ptr;
    logic [2:0] winner;
    logic       found;
    logic [3:0] idx;
    logic       flit_ok;
    logic       sel_valid;

    // Scan upward from rr_ptr, wrapping 4->0; the first request found wins.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < 5; i++) begin
            idx = {1'b0, rr_ptr} + 4'(i);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!found && route_req_in[idx[2:0]]) begin
                winner = idx[2:0];
                found  = 1'b1;
            end
        end
    end

    assign locked    = (state == LOCKED);
    assign sel_valid = valid_in[current_route];
    assign flit_ok   = (credit_cnt != '0);
    assign valid_out = locked & sel_valid & flit_ok;
    assign thanks_out = valid_out ? (5'b00001 << current_route) : 5'b00000;
    assign ec_wants_to_send_but_cannot = locked & sel_valid & (credit_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= 3'd0;
            current_route <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        current_route <= winner;
                        state         <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (valid_out && tail_in[current_route]) begin
                        state  <= IDLE;
                        rr_ptr <= (current_route == 3'd4) ? 3'd0 : current_route + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A send and a return in the same cycle cancel; a return with a full
    // counter is a downstream protocol error and is latched until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_cnt          <= CNT_W'(CREDITS);
            credit_overflow_err <= 1'b0;
        end else begin
            if (valid_out && !yummy_in) begin
                credit_cnt <= credit_cnt - 1'b1;
            end else if (yummy_in && !valid_out) begin
                if (credit_cnt == CNT_W'(CREDITS))
                    credit_overflow_err <= 1'b1;
                else
                    credit_cnt <= credit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dynamic_output_rr_scheduler.sv
// Directed bench for dynamic_output_rr_scheduler with hand-computed expectations.
module tb_dynamic_output_rr_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] route_req_in;
    logic [4:0] valid_in;
    logic [4:0] tail_in;
    logic       yummy_in;
    logic [2:0] current_route;
    logic       valid_out;
    logic [4:0] thanks_out;
    logic       locked;
    logic [2:0] credit_cnt;
    logic       ec_wants_to_send_but_cannot;
    logic       credit_overflow_err;

    int total = 0;
    int bad   = 0;
    int thanks_b;

    dynamic_output_rr_scheduler #(.CREDITS(4), .CNT_W(3)) dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .route_req_in                (route_req_in),
        .valid_in                    (valid_in),
        .tail_in                     (tail_in),
        .yummy_in                    (yummy_in),
        .current_route               (current_route),
        .valid_out                   (valid_out),
        .thanks_out                  (thanks_out),
        .locked                      (locked),
        .credit_cnt                  (credit_cnt),
        .ec_wants_to_send_but_cannot (ec_wants_to_send_but_cannot),
        .credit_overflow_err         (credit_overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, then let combinational outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n = 1'b0; route_req_in = '0; valid_in = '0; tail_in = '0; yummy_in = 1'b0;
        repeat (2) step();
        chk("rst_locked", locked, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_thanks", thanks_out, 0);
        chk("rst_credit", credit_cnt, 4);
        chk("rst_err", credit_overflow_err, 0);
        chk("rst_route", current_route, 0);
        chk("rst_ec", ec_wants_to_send_but_cannot, 0);

        // Round-robin over A, C, X with single-flit packets.
        reset_n = 1'b1; route_req_in = 5'b10101; settle();
        chk("arb_cycle_valid", valid_out, 0);
        step();
        chk("grant_a_locked", locked, 1);
        chk("grant_a_route", current_route, 0);
        valid_in = 5'b00001; tail_in = 5'b00001; settle();
        chk("a_valid", valid_out, 1);
        chk("a_thanks", thanks_out, 5'b00001);
        step();
        chk("a_release", locked, 0);
        chk("a_credit", credit_cnt, 3);
        valid_in = '0; tail_in = '0; yummy_in = 1'b1; step();
        chk("grant_c_route", current_route, 2);
        chk("grant_c_credit", credit_cnt, 4);
        yummy_in = 1'b0; valid_in = 5'b00100; tail_in = 5'b00100; settle();
        chk("c_thanks", thanks_out, 5'b00100);
        step();
        valid_in = '0; tail_in = '0; yummy_in = 1'b1; step();
        chk("grant_x_route", current_route, 4);
        yummy_in = 1'b0; valid_in = 5'b10000; tail_in = 5'b10000; settle();
        chk("x_thanks", thanks_out, 5'b10000);
        step();
        valid_in = '0; tail_in = '0; yummy_in = 1'b1; step();
        chk("grant_a2_route", current_route, 0);
        chk("grant_a2_locked", locked, 1);
        route_req_in = '0; yummy_in = 1'b0; valid_in = 5'b00001; tail_in = 5'b00001; step();
        valid_in = '0; tail_in = '0; yummy_in = 1'b1; step();
        chk("no_req_idle", locked, 0);
        chk("restore_credit", credit_cnt, 4);
        yummy_in = 1'b0;

        // Three-flit packet on B with a one-cycle gap; requests ignored while locked.
        thanks_b = 0;
        route_req_in = 5'b00010; step();
        chk("grant_b_route", current_route, 1);
        route_req_in = 5'b11111;
        valid_in = 5'b00010; settle();
        if (thanks_out == 5'b00010) thanks_b++;
        step();
        valid_in = '0; settle();
        chk("b_gap_valid", valid_out, 0);
        chk("b_gap_locked", locked, 1);
        if (thanks_out == 5'b00010) thanks_b++;
        step();
        valid_in = 5'b00010; settle();
        chk("b_req_ignored", current_route, 1);
        if (thanks_out == 5'b00010) thanks_b++;
        step();
        tail_in = 5'b00010; route_req_in = '0; settle();
        chk("b_tail_locked", locked, 1);
        if (thanks_out == 5'b00010) thanks_b++;
        step();
        chk("b_thanks_count", thanks_b, 3);
        chk("b_release", locked, 0);
        chk("b_credit", credit_cnt, 1);
        valid_in = '0; tail_in = '0; yummy_in = 1'b1;
        repeat (3) step();
        yummy_in = 1'b0;
        chk("b_restore", credit_cnt, 4);

        // Five flits on D with no returns: fifth stalls until one yummy.
        route_req_in = 5'b01000; step();
        chk("grant_d_route", current_route, 3);
        route_req_in = '0; valid_in = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("d_flit_valid", valid_out, 1);
            step();
        end
        tail_in = 5'b01000; settle();
        chk("d_credit_zero", credit_cnt, 0);
        chk("d_stall_valid", valid_out, 0);
        chk("d_stall_ec", ec_wants_to_send_but_cannot, 1);
        step();
        chk("d_stall_ec2", ec_wants_to_send_but_cannot, 1);
        yummy_in = 1'b1; settle();
        chk("d_yummy_cycle_valid", valid_out, 0);
        step();
        yummy_in = 1'b0; settle();
        chk("d_flit5_valid", valid_out, 1);
        chk("d_flit5_thanks", thanks_out, 5'b01000);
        step();
        chk("d_release", locked, 0);
        valid_in = '0; tail_in = '0; yummy_in = 1'b1;
        repeat (4) step();
        yummy_in = 1'b0;
        chk("d_restore", credit_cnt, 4);

        // rr_ptr=4, A requests -> wraps to A; send+return in same cycle at 2.
        route_req_in = 5'b00001; step();
        chk("wrap_grant_a", current_route, 0);
        route_req_in = '0; valid_in = 5'b00001;
        repeat (2) step();
        chk("credit_two", credit_cnt, 2);
        tail_in = 5'b00001; yummy_in = 1'b1; step();
        chk("same_cycle_credit", credit_cnt, 2);
        chk("same_cycle_release", locked, 0);
        valid_in = '0; tail_in = '0;
        repeat (2) step();
        chk("full_credit", credit_cnt, 4);
        chk("no_err_yet", credit_overflow_err, 0);
        step();
        yummy_in = 1'b0;
        chk("overflow_credit", credit_cnt, 4);
        chk("overflow_err", credit_overflow_err, 1);
        step();
        chk("overflow_sticky", credit_overflow_err, 1);

        // Reset mid-packet on D with one credit left (rr_ptr=1 beforehand).
        route_req_in = 5'b01000; step();
        chk("grant_d2_route", current_route, 3);
        route_req_in = '0; valid_in = 5'b01000;
        repeat (3) step();
        chk("d2_credit_one", credit_cnt, 1);
        #2 reset_n = 1'b0; #1;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_credit", credit_cnt, 4);
        chk("mid_rst_err", credit_overflow_err, 0);
        chk("mid_rst_route", current_route, 0);
        step();
        reset_n = 1'b1; valid_in = '0; route_req_in = 5'b01001; step();
        chk("post_rst_grant", current_route, 0);
        route_req_in = 5'b01000; valid_in = 5'b00001; tail_in = 5'b00001; step();
        valid_in = '0; tail_in = '0; step();
        chk("post_rst_grant_d", current_route, 3);
        chk("post_rst_locked", locked, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dynamic_output_rr_scheduler.md
DYNAMIC_OUTPUT_RR_SCHEDULER -- requirements
Module: dynamic_output_rr_scheduler

Interface
REQ-001 SHALL have parameter CREDITS, default 4, giving downstream buffer depth in flits (legal range 1..7).
REQ-002 SHALL have parameter CNT_W, default 3, giving the credit counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port route_req_in, input, 5 bits: per-requester route request; bits 0..4 = A, B, C, D, X.
REQ-006 SHALL have port valid_in, input, 5 bits: per-requester flit valid.
REQ-007 SHALL have port tail_in, input, 5 bits: per-requester flit-is-tail.
REQ-008 SHALL have port yummy_in, input, 1 bit: one-cycle credit return from downstream.
REQ-009 SHALL have port current_route, output, 3 bits: datapath mux select; A=0, B=1, C=2, D=3, X=4.
REQ-010 SHALL have port valid_out, output, 1 bit: flit forwarded this cycle.
REQ-011 SHALL have port thanks_out, output, 5 bits: one-hot dequeue pulse to the granted requester.
REQ-012 SHALL have port locked, output, 1 bit: a wormhole route is held.
REQ-013 SHALL have port credit_cnt, output, CNT_W bits: current downstream credits.
REQ-014 SHALL have port ec_wants_to_send_but_cannot, output, 1 bit: granted flit stalled for credit.
REQ-015 SHALL have port credit_overflow_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-016 SHALL implement two states: IDLE and LOCKED.
REQ-017 In IDLE with any route_req_in bit set, SHALL pick the winner round-robin, searching upward from rr_ptr with wrap 4->0.
REQ-018 SHALL register the winner into current_route and enter LOCKED on the next edge; there are no forwarded flits in the arbitration cycle.
REQ-019 In IDLE, current_route SHALL hold its last value, valid_out=0 and thanks_out=0.
REQ-020 In LOCKED, valid_out SHALL equal valid_in[current_route] & (credit_cnt!=0), combinationally.
REQ-021 thanks_out SHALL be one-hot at bit current_route when valid_out=1, else 0.
REQ-022 In LOCKED, route_req_in changes SHALL be ignored; the route is held until its tail.
REQ-023 valid_out & tail_in[current_route] SHALL return the block to IDLE on the next edge and set rr_ptr = (current_route+1) mod 5.
REQ-024 A header that is also a tail (single-flit packet) SHALL release the route after that one flit.
REQ-025 credit_cnt SHALL decrement by 1 on valid_out, increment by 1 on yummy_in, and stay unchanged when both occur in the same cycle.
REQ-026 valid_out SHALL never assert when credit_cnt=0.
REQ-027 A yummy_in without valid_out while credit_cnt=CREDITS SHALL leave credit_cnt unchanged and set credit_overflow_err, which holds until reset.
REQ-028 ec_wants_to_send_but_cannot SHALL equal locked & valid_in[current_route] & (credit_cnt==0).
REQ-029 An IDLE->LOCKED transition SHALL NOT take place on a cycle with no requests; the block remains in IDLE.

Reset
REQ-030 reset_n low SHALL, asynchronously and regardless of state (including mid-packet), force: state=IDLE, rr_ptr=0, current_route=0, credit_cnt=CREDITS, credit_overflow_err=0.
REQ-031 During reset, outputs SHALL read valid_out=0, thanks_out=0, locked=0, and ec_wants_to_send_but_cannot=0.
REQ-032 After reset deassertion, the first arbitration SHALL give requester A highest priority.

Verification
REQ-033 Simultaneous requests 5'b10101 from reset -> grant A; after A's tail, grant C; after C's tail, grant X; then A again.
REQ-034 Three-flit packet on B with valid_in[1] gapped one cycle -> thanks_out=5'b00010 exactly 3 times; valid_out low during the gap; locked stays 1 until the edge after the tail.
REQ-035 CREDITS=4, five flits, no yummy_in -> 4 flits forwarded; credit_cnt reaches 0; ec_wants_to_send_but_cannot=1 on flit 5; one yummy_in releases flit 5 on the following cycle.
REQ-036 valid_out and yummy_in in the same cycle at credit_cnt=2 -> credit_cnt stays 2; yummy_in at credit_cnt=4 with idle output -> credit_cnt=4 and credit_overflow_err=1 until reset.
REQ-037 reset_n pulsed low mid-packet on D with credit_cnt=1 -> immediately locked=0, valid_out=0, credit_cnt=4; next request from D re-arbitrates from rr_ptr=0.
